// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control sequencer: opcodes, ALU encodings,
// sequencer states, instruction field positions and the control bundle.
package cpu_pkg;

    localparam int PC_W_DEFAULT = 32;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 24;
    localparam int OFF_MSB   = 23;
    localparam int OFF_LSB   = 16;
    localparam int WREG_MSB  = 18;
    localparam int WREG_LSB  = 16;
    localparam int RREG1_MSB = 10;
    localparam int RREG1_LSB = 8;
    localparam int RREG2_MSB = 2;
    localparam int RREG2_LSB = 0;
    localparam int IMM_MSB   = 7;
    localparam int IMM_LSB   = 0;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       complement;
        logic       immediate;
        logic       wb_sel;
        logic       is_alu;
        logic       is_mem;
        logic       is_load;
        logic       is_branch;
        logic       is_jump;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Memory handshake and datapath control bundle between the sequencer (master)
// and the memories/datapath (slave).
interface cpu_sequencer_if #(
    parameter int PC_W = cpu_pkg::PC_W_DEFAULT
);
    logic [31:0]     INSTRUCTION;
    logic            IMEM_BUSYWAIT;
    logic            IMEM_READ;
    logic [PC_W-1:0] PC;
    logic            ZERO;
    logic            DMEM_BUSYWAIT;
    logic            DMEM_READ;
    logic            DMEM_WRITE;
    logic            WRITEENABLE;
    logic [2:0]      ALUOP;
    logic            COMPLEMENT_FLAG;
    logic            IMMEDIATE_FLAG;
    logic            WB_SEL;
    logic [2:0]      WRITEREG;
    logic [2:0]      READREG1;
    logic [2:0]      READREG2;
    logic [7:0]      IMMEDIATE;

    modport master (
        input  INSTRUCTION, IMEM_BUSYWAIT, ZERO, DMEM_BUSYWAIT,
        output IMEM_READ, PC, DMEM_READ, DMEM_WRITE, WRITEENABLE, ALUOP,
               COMPLEMENT_FLAG, IMMEDIATE_FLAG, WB_SEL,
               WRITEREG, READREG1, READREG2, IMMEDIATE
    );

    modport slave (
        output INSTRUCTION, IMEM_BUSYWAIT, ZERO, DMEM_BUSYWAIT,
        input  IMEM_READ, PC, DMEM_READ, DMEM_WRITE, WRITEENABLE, ALUOP,
               COMPLEMENT_FLAG, IMMEDIATE_FLAG, WB_SEL,
               WRITEREG, READREG1, READREG2, IMMEDIATE
    );
endinterface

// File: rtl/instr_decoder.sv
// Purely combinational opcode decoder producing the datapath control bundle.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    output ctrl_t      ctrl
);

    // Opcode to control bundle; anything outside the defined set is flagged illegal.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_LOADI: begin ctrl.immediate = 1'b1; ctrl.is_alu = 1'b1; end
            OP_MOV:   begin ctrl.is_alu = 1'b1; end
            OP_ADD:   begin ctrl.alu_op = ALU_ADD; ctrl.is_alu = 1'b1; end
            OP_SUB:   begin ctrl.alu_op = ALU_ADD; ctrl.complement = 1'b1; ctrl.is_alu = 1'b1; end
            OP_AND:   begin ctrl.alu_op = ALU_AND; ctrl.is_alu = 1'b1; end
            OP_OR:    begin ctrl.alu_op = ALU_OR;  ctrl.is_alu = 1'b1; end
            OP_J:     begin ctrl.is_jump = 1'b1; end
            OP_BEQ:   begin ctrl.alu_op = ALU_ADD; ctrl.complement = 1'b1; ctrl.is_branch = 1'b1; end
            OP_LWD:   begin ctrl.is_mem = 1'b1; ctrl.is_load = 1'b1; ctrl.wb_sel = 1'b1; end
            OP_LWI:   begin ctrl.is_mem = 1'b1; ctrl.is_load = 1'b1; ctrl.wb_sel = 1'b1; ctrl.immediate = 1'b1; end
            OP_SWD:   begin ctrl.is_mem = 1'b1; end
            OP_SWI:   begin ctrl.is_mem = 1'b1; ctrl.immediate = 1'b1; end
            default:  begin ctrl.illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR.
// Define ILLEGAL_OP_TRAP_EN to halt on illegal opcodes and expose ILLEGAL_OP.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic CLK,
    input  logic RESET,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic ILLEGAL_OP,
`endif
    cpu_sequencer_if.master bus
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [PC_W-1:0] pc_inc, pc_tgt;
    ctrl_t           dec;
    logic            active;

    logic       imem_read_q, imem_read_d;
    logic       dmem_read_q, dmem_read_d;
    logic       dmem_write_q, dmem_write_d;
    logic       we_q, we_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic       comp_q, comp_d;
    logic       imm_q, imm_d;
    logic       wb_sel_q, wb_sel_d;
    logic       illegal_op_q, illegal_op_d;

    // INSTRUCTION is captured only on the edge that ends a ready fetch.
    assign ir_d   = (state_q == ST_FETCH && !bus.IMEM_BUSYWAIT) ? bus.INSTRUCTION : ir_q;
    assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign pc_tgt = pc_inc + {{(PC_W-8){ir_q[OFF_MSB]}}, ir_q[OFF_MSB:OFF_LSB]};

    instr_decoder u_dec (
        .opcode (ir_d[OPC_MSB:OPC_LSB]),
        .ctrl   (dec)
    );

    // Next state and PC, then outputs decoded from the state being entered so they register cleanly.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            ST_FETCH: begin
                if (!bus.IMEM_BUSYWAIT) state_d = ST_DECODE;
                else                    state_d = ST_FETCH;
            end
            ST_DECODE: begin
                if (dec.is_mem) state_d = ST_MEM;
                else            state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (dec.is_jump || (dec.is_branch && bus.ZERO)) begin
                    pc_d = pc_tgt;
                end else if (dec.illegal) begin
`ifdef ILLEGAL_OP_TRAP_EN
                    state_d = ST_HALT;
                    pc_d    = pc_q;
`else
                    pc_d    = pc_inc;
`endif
                end else begin
                    pc_d = pc_inc;
                end
            end
            ST_MEM: begin
                if (!bus.DMEM_BUSYWAIT) begin
                    if (dec.is_load) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = pc_inc;
                    end
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
            end
            ST_HALT: begin
`ifdef ILLEGAL_OP_TRAP_EN
                state_d = ST_HALT;
`else
                state_d = ST_FETCH;
`endif
            end
            default: state_d = ST_FETCH;
        endcase

        active       = state_d inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB};
        imem_read_d  = (state_d == ST_FETCH);
        dmem_read_d  = (state_d == ST_MEM) && dec.is_load;
        dmem_write_d = (state_d == ST_MEM) && !dec.is_load;
        we_d         = ((state_d == ST_EXEC) && dec.is_alu) || (state_d == ST_WB);
        alu_op_d     = active ? dec.alu_op     : ALU_FWD;
        comp_d       = active ? dec.complement : 1'b0;
        imm_d        = active ? dec.immediate  : 1'b0;
        wb_sel_d     = active ? dec.wb_sel     : 1'b0;
        illegal_op_d = (state_d == ST_HALT);
    end

    // Sequencer registers; RESET abandons any transaction and restarts a clean fetch.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            ir_q         <= 32'd0;
            imem_read_q  <= 1'b1;
            dmem_read_q  <= 1'b0;
            dmem_write_q <= 1'b0;
            we_q         <= 1'b0;
            alu_op_q     <= ALU_FWD;
            comp_q       <= 1'b0;
            imm_q        <= 1'b0;
            wb_sel_q     <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            imem_read_q  <= imem_read_d;
            dmem_read_q  <= dmem_read_d;
            dmem_write_q <= dmem_write_d;
            we_q         <= we_d;
            alu_op_q     <= alu_op_d;
            comp_q       <= comp_d;
            imm_q        <= imm_d;
            wb_sel_q     <= wb_sel_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    assign bus.IMEM_READ       = imem_read_q;
    assign bus.PC              = pc_q;
    assign bus.DMEM_READ       = dmem_read_q;
    assign bus.DMEM_WRITE      = dmem_write_q;
    assign bus.WRITEENABLE     = we_q;
    assign bus.ALUOP           = alu_op_q;
    assign bus.COMPLEMENT_FLAG = comp_q;
    assign bus.IMMEDIATE_FLAG  = imm_q;
    assign bus.WB_SEL          = wb_sel_q;
    assign bus.WRITEREG        = ir_q[WREG_MSB:WREG_LSB];
    assign bus.READREG1        = ir_q[RREG1_MSB:RREG1_LSB];
    assign bus.READREG2        = ir_q[RREG2_MSB:RREG2_LSB];
    assign bus.IMMEDIATE       = ir_q[IMM_MSB:IMM_LSB];

`ifdef ILLEGAL_OP_TRAP_EN
    assign ILLEGAL_OP = illegal_op_q;
`else
    logic unused_illegal_op;
    assign unused_illegal_op = illegal_op_q;
`endif

    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[15:11];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus random instruction
// streams scored against a per-instruction transaction model.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    cpu_sequencer_if #(.PC_W(32)) bus ();
`ifdef ILLEGAL_OP_TRAP_EN
    logic ILLEGAL_OP;
`endif

    cpu_sequencer #(.PC_W(32), .RESET_PC(32'd0)) dut (
        .CLK   (CLK),
        .RESET (RESET),
`ifdef ILLEGAL_OP_TRAP_EN
        .ILLEGAL_OP (ILLEGAL_OP),
`endif
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] pc_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One instruction from its first fetch cycle until the next fetch begins.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int ib, input int db);
        logic [7:0]  op;
        logic [31:0] off, exp_pc;
        int          exp_cyc, exp_we, exp_rd, exp_wr;
        logic [2:0]  exp_alu;
        logic        exp_comp, exp_imm, chk_ctrl;
        int          cyc, fc, mc, we_n, we_at, rd_n, wr_n, excl, unstable;
        logic        left, seen;
        logic [2:0]  c_alu, wreg, r1, r2;
        logic        c_comp, c_imm, c_wbsel;
        logic [7:0]  imm;

        op       = ins[31:24];
        off      = {{24{ins[23]}}, ins[23:16]};
        exp_pc   = pc_m + 32'd1;
        exp_cyc  = ib + 3;
        exp_we   = 0; exp_rd = 0; exp_wr = 0;
        chk_ctrl = 1'b1; exp_alu = 3'b000; exp_comp = 1'b0; exp_imm = 1'b0;
        case (op)
            8'h00: begin exp_imm = 1'b1; exp_we = 1; end
            8'h01: begin exp_we = 1; end
            8'h02: begin exp_alu = 3'b001; exp_we = 1; end
            8'h03: begin exp_alu = 3'b001; exp_comp = 1'b1; exp_we = 1; end
            8'h04: begin exp_alu = 3'b010; exp_we = 1; end
            8'h05: begin exp_alu = 3'b011; exp_we = 1; end
            8'h06: begin chk_ctrl = 1'b0; exp_pc = pc_m + 32'd1 + off; end
            8'h07: begin exp_alu = 3'b001; exp_comp = 1'b1; if (z) exp_pc = pc_m + 32'd1 + off; end
            8'h08: begin exp_cyc = ib + db + 4; exp_we = 1; exp_rd = db + 1; end
            8'h09: begin exp_cyc = ib + db + 4; exp_we = 1; exp_rd = db + 1; exp_imm = 1'b1; end
            8'h0A: begin exp_cyc = ib + db + 3; exp_wr = db + 1; end
            8'h0B: begin exp_cyc = ib + db + 3; exp_wr = db + 1; exp_imm = 1'b1; end
            default: chk_ctrl = 1'b0;
        endcase

        bus.ZERO = z;
        cyc = 0; fc = 0; mc = 0; we_n = 0; we_at = 0; rd_n = 0; wr_n = 0;
        excl = 0; unstable = 0; left = 1'b0; seen = 1'b0;
        c_alu = 3'bx; c_comp = 1'bx; c_imm = 1'bx; c_wbsel = 1'bx;
        wreg = 3'bx; r1 = 3'bx; r2 = 3'bx; imm = 8'bx;
        while (cyc < 60) begin
            if (bus.IMEM_READ && left) break;
            cyc++;
            if (bus.IMEM_READ && (bus.DMEM_READ || bus.DMEM_WRITE)) excl++;
            if (bus.IMEM_READ) begin
                bus.IMEM_BUSYWAIT = (fc < ib);
                bus.INSTRUCTION   = (fc < ib) ? $urandom() : ins;
                fc++;
            end else begin
                left = 1'b1;
                bus.IMEM_BUSYWAIT = 1'($urandom_range(1));
                bus.INSTRUCTION   = $urandom();
                if (!seen) begin
                    seen = 1'b1;
                    c_alu = bus.ALUOP; c_comp = bus.COMPLEMENT_FLAG; c_imm = bus.IMMEDIATE_FLAG;
                    wreg = bus.WRITEREG; r1 = bus.READREG1; r2 = bus.READREG2; imm = bus.IMMEDIATE;
                end else if ({bus.ALUOP, bus.COMPLEMENT_FLAG, bus.IMMEDIATE_FLAG} !== {c_alu, c_comp, c_imm}) begin
                    unstable++;
                end
            end
            if (bus.DMEM_READ || bus.DMEM_WRITE) begin
                bus.DMEM_BUSYWAIT = (mc < db);
                mc++;
                if (bus.DMEM_READ)  rd_n++;
                if (bus.DMEM_WRITE) wr_n++;
            end else begin
                bus.DMEM_BUSYWAIT = 1'($urandom_range(1));
            end
            if (bus.WRITEENABLE) begin
                we_n++;
                we_at   = cyc;
                c_wbsel = bus.WB_SEL;
            end
            tick();
        end

        check($sformatf("cycles op=%0h", op), 32'(cyc), 32'(exp_cyc));
        check($sformatf("pc op=%0h", op), bus.PC, exp_pc);
        check($sformatf("we_count op=%0h", op), 32'(we_n), 32'(exp_we));
        check($sformatf("dmem_read_cycles op=%0h", op), 32'(rd_n), 32'(exp_rd));
        check($sformatf("dmem_write_cycles op=%0h", op), 32'(wr_n), 32'(exp_wr));
        check("req_exclusive", 32'(excl), 32'd0);
        check($sformatf("ir_fields op=%0h", op), 32'({wreg, r1, r2, imm}),
              32'({ins[18:16], ins[10:8], ins[2:0], ins[7:0]}));
        if (chk_ctrl) begin
            check($sformatf("ctrl op=%0h", op), 32'({c_alu, c_comp, c_imm}), 32'({exp_alu, exp_comp, exp_imm}));
            check($sformatf("ctrl_stable op=%0h", op), 32'(unstable), 32'd0);
        end
        if (exp_we != 0) begin
            check($sformatf("we_last_cycle op=%0h", op), 32'(we_at), 32'(exp_cyc));
            check($sformatf("wb_sel op=%0h", op), 32'(c_wbsel), 32'(exp_rd != 0));
        end
        pc_m = exp_pc;
    endtask

    initial begin
        RESET = 1'b1;
        bus.INSTRUCTION = 32'd0; bus.IMEM_BUSYWAIT = 1'b0;
        bus.ZERO = 1'b0; bus.DMEM_BUSYWAIT = 1'b0;
        tick();
        tick();
        check("rst_pc", bus.PC, 32'd0);
        check("rst_strobes", 32'({bus.DMEM_READ, bus.DMEM_WRITE, bus.WRITEENABLE}), 32'd0);
        check("rst_ctrl", 32'({bus.ALUOP, bus.COMPLEMENT_FLAG, bus.IMMEDIATE_FLAG, bus.WB_SEL}), 32'd0);
        RESET = 1'b0;
        pc_m  = 32'd0;
        check("rst_then_fetch", 32'(bus.IMEM_READ), 32'd1);

        run_instr(32'h02050102, 1'b0, 0, 0);   // add, PC 0 -> 1, 3 cycles
        run_instr(32'h03010203, 1'b0, 4, 0);   // sub with 4 fetch waits, 7 cycles
        run_instr(32'h04020304, 1'b0, 0, 0);
        run_instr(32'h05030405, 1'b0, 1, 0);
        run_instr(32'h01040506, 1'b0, 0, 0);   // PC now 5
        run_instr(32'h06FE0000, 1'b0, 0, 0);   // j -2: PC 4
        for (int k = 0; k < 6; k++) run_instr(32'h000100A5, 1'b0, 0, 0);   // PC 10
        run_instr(32'h07030102, 1'b1, 0, 0);   // beq taken: PC 14
        run_instr(32'h06FB0000, 1'b0, 0, 0);   // j -5: PC 10
        run_instr(32'h07030102, 1'b0, 0, 0);   // beq not taken: PC 11
        run_instr(32'h09020055, 1'b0, 0, 2);   // lwi, 2 data waits, 6 cycles
        run_instr(32'h0B000066, 1'b0, 0, 1);
        run_instr(32'h08030100, 1'b0, 1, 0);
        run_instr(32'h0A000304, 1'b0, 0, 0);

`ifdef ILLEGAL_OP_TRAP_EN
        bus.INSTRUCTION = 32'hFF000000; bus.IMEM_BUSYWAIT = 1'b0;
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            check("halt_illegal_op", 32'(ILLEGAL_OP), 32'd1);
            check("halt_pc", bus.PC, pc_m);
            check("halt_no_req", 32'({bus.IMEM_READ, bus.DMEM_READ, bus.DMEM_WRITE, bus.WRITEENABLE}), 32'd0);
            tick();
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("halt_exit_illegal_op", 32'(ILLEGAL_OP), 32'd0);
        check("halt_exit_fetch", 32'(bus.IMEM_READ), 32'd1);
        check("halt_exit_pc", bus.PC, 32'd0);
        pc_m = 32'd0;
`else
        run_instr(32'hFF000000, 1'b0, 0, 0);   // illegal opcode behaves as NOP
        run_instr(32'h0C123456, 1'b0, 1, 0);
`endif

        // Reset in the middle of a stalled store.
        bus.INSTRUCTION = 32'h0A000304; bus.IMEM_BUSYWAIT = 1'b0; bus.DMEM_BUSYWAIT = 1'b1;
        tick();
        tick();
        check("mid_mem_write", 32'(bus.DMEM_WRITE), 32'd1);
        tick();
        check("mid_mem_write_held", 32'(bus.DMEM_WRITE), 32'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        bus.DMEM_BUSYWAIT = 1'b0;
        check("mid_mem_rst_write", 32'(bus.DMEM_WRITE), 32'd0);
        check("mid_mem_rst_pc", bus.PC, 32'd0);
        check("mid_mem_rst_fetch", 32'(bus.IMEM_READ), 32'd1);
        pc_m = 32'd0;

        run_instr(32'h06FE0000, 1'b0, 0, 0);   // PC 0 - 1 wraps to all-ones
        run_instr(32'h02010203, 1'b0, 0, 0);   // wraps back to 0

        for (int k = 0; k < 40; k++) begin
            logic [31:0] ins;
            int          sel;
            ins = $urandom();
`ifdef ILLEGAL_OP_TRAP_EN
            sel = int'($urandom_range(11));
`else
            sel = int'($urandom_range(12));
`endif
            if (sel == 12) ins[31:24] = 8'($urandom_range(255, 12));
            else           ins[31:24] = 8'(sel);
            run_instr(ins, 1'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
